// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
// Holds the fetch-stage state encoding and the fixed instruction words.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } if_state_e;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write port (negedge) for debug loading,
// combinational read port for fetch. No reset, so contents survive a reset.
module instr_mem #(
    parameter int len_data  = 32,
    parameter int mem_depth = 256,
    parameter int addr_bits = $clog2(mem_depth)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [addr_bits-1:0] waddr_i,
    input  logic [len_data-1:0]  wdata_i,
    input  logic [addr_bits-1:0] raddr_i,
    output logic [len_data-1:0]  rdata_o
);

    logic [len_data-1:0] mem_q [mem_depth];

    always_ff @(negedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, LOAD/RUN/HALTED
// control and the IF/ID latch. All state updates on the falling clock edge.
module if_stage
    import mips_pkg::*;
#(
    parameter int len_data  = 32,
    parameter int mem_depth = 256,
    parameter int addr_bits = $clog2(mem_depth)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 step,
    input  logic                 dbg_we,
    input  logic [addr_bits-1:0] dbg_addr,
    input  logic [len_data-1:0]  dbg_data,
    input  logic                 load_done,
    input  logic                 stall_flag,
    input  logic                 flag_jump,
    input  logic                 flag_jump_register,
    input  logic [len_data-1:0]  pc_jump,
    input  logic [len_data-1:0]  pc_jump_register,
    input  logic                 flag_branch,
    input  logic [len_data-1:0]  pc_branch_target,
    output logic [len_data-1:0]  out_pc_branch,
    output logic [len_data-1:0]  out_instruccion,
    output logic                 flush,
    output logic                 out_halt_flag_d,
    output logic [len_data-1:0]  out_pc
);

    if_state_e           state_q, state_d;
    logic [len_data-1:0] pc_q, pc_d;
    logic [len_data-1:0] ir_q, ir_d;
    logic [len_data-1:0] pcb_q, pcb_d;
    logic                halt_q, halt_d;

    logic                mem_we;
    logic [len_data-1:0] fetch_word;
    logic [len_data-1:0] pc_plus4;
    logic [len_data-1:0] redirect_pc;
    logic                redirect;
    logic                advance;

    instr_mem #(
        .len_data  (len_data),
        .mem_depth (mem_depth),
        .addr_bits (addr_bits)
    ) u_instr_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (dbg_addr),
        .wdata_i (dbg_data),
        .raddr_i (pc_q[addr_bits+1:2]),
        .rdata_o (fetch_word)
    );

    assign pc_plus4 = pc_q + len_data'(PC_STEP);
    assign redirect = flag_branch | flag_jump_register | flag_jump;
    assign advance  = enable | step;

    // The branch belongs to the older instruction, so it beats both jumps.
    always_comb begin
        redirect_pc = pc_jump;
        if (flag_branch) begin
            redirect_pc = pc_branch_target;
        end else if (flag_jump_register) begin
            redirect_pc = pc_jump_register;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcb_d   = pcb_q;
        halt_d  = halt_q;
        flush   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                pc_d   = '0;
                mem_we = dbg_we;
                if (load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                    ir_d  = len_data'(NOP_WORD);
                    pcb_d = pc_plus4;
                end else if (!stall_flag && advance) begin
                    pc_d  = pc_plus4;
                    ir_d  = fetch_word;
                    pcb_d = pc_plus4;
                    if (fetch_word == len_data'(HALT_WORD)) begin
                        halt_d  = 1'b1;
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            pc_q    <= '0;
            ir_q    <= '0;
            pcb_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcb_q   <= pcb_d;
            halt_q  <= halt_d;
        end
    end

    assign out_pc          = pc_q;
    assign out_instruccion = ir_q;
    assign out_pc_branch   = pcb_q;
    assign out_halt_flag_d = halt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic, all checked
// against a behavioural fetch model with its own copy of the program memory.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        step;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        load_done;
    logic        stall_flag;
    logic        flag_jump;
    logic        flag_jump_register;
    logic [31:0] pc_jump;
    logic [31:0] pc_jump_register;
    logic        flag_branch;
    logic [31:0] pc_branch_target;
    logic [31:0] out_pc_branch;
    logic [31:0] out_instruccion;
    logic        flush;
    logic        out_halt_flag_d;
    logic [31:0] out_pc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [256];
    bit          m_run;
    bit          m_halt;
    logic [31:0] m_pc, m_ir, m_pcb;
    logic [31:0] saved_pc;

    if_stage #(
        .len_data  (32),
        .mem_depth (256),
        .addr_bits (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .step               (step),
        .dbg_we             (dbg_we),
        .dbg_addr           (dbg_addr),
        .dbg_data           (dbg_data),
        .load_done          (load_done),
        .stall_flag         (stall_flag),
        .flag_jump          (flag_jump),
        .flag_jump_register (flag_jump_register),
        .pc_jump            (pc_jump),
        .pc_jump_register   (pc_jump_register),
        .flag_branch        (flag_branch),
        .pc_branch_target   (pc_branch_target),
        .out_pc_branch      (out_pc_branch),
        .out_instruccion    (out_instruccion),
        .flush              (flush),
        .out_halt_flag_d    (out_halt_flag_d),
        .out_pc             (out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_flush();
        return m_run && !m_halt && (flag_branch || flag_jump_register || flag_jump);
    endfunction

    // One falling edge of the reference fetch model.
    task automatic model_step();
        logic [31:0] w;
        if (!m_run) begin
            if (dbg_we) m_mem[dbg_addr] = dbg_data;
            m_pc = 0;
            if (load_done) m_run = 1;
        end else if (!m_halt) begin
            if (flag_branch || flag_jump_register || flag_jump) begin
                m_ir  = 0;
                m_pcb = m_pc + 4;
                if (flag_branch)             m_pc = pc_branch_target;
                else if (flag_jump_register) m_pc = pc_jump_register;
                else                         m_pc = pc_jump;
            end else if (!stall_flag && (enable || step)) begin
                w     = m_mem[(m_pc / 4) % 256];
                m_ir  = w;
                m_pcb = m_pc + 4;
                m_pc  = m_pc + 4;
                if (w == 32'hFFFF_FFFF) m_halt = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("pc", out_pc, m_pc);
        chk("instr", out_instruccion, m_ir);
        chk("pc_branch", out_pc_branch, m_pcb);
        chk("halt_flag", {31'b0, out_halt_flag_d}, {31'b0, m_halt});
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic tick();
        #1 chk("flush", {31'b0, flush}, {31'b0, model_flush()});
        model_step();
        @(negedge clk);
        @(posedge clk);
        check_all();
    endtask

    task automatic clear_in();
        enable = 0; step = 0; dbg_we = 0; dbg_addr = 0; dbg_data = 0;
        load_done = 0; stall_flag = 0; flag_jump = 0; flag_jump_register = 0;
        flag_branch = 0; pc_jump = 0; pc_jump_register = 0; pc_branch_target = 0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        #1;
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instruccion, 32'h0);
        chk("rst_pc_branch", out_pc_branch, 32'h0);
        chk("rst_halt", {31'b0, out_halt_flag_d}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        m_run = 0; m_halt = 0; m_pc = 0; m_ir = 0; m_pcb = 0;
        @(negedge clk);
        @(posedge clk);
        reset = 0;
        check_all();
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        dbg_we = 1; dbg_addr = 8'(addr); dbg_data = data;
        tick();
        dbg_we = 0;
    endtask

    task automatic go();
        load_done = 1;
        tick();
        load_done = 0;
    endtask

    initial begin
        clear_in();
        reset = 0;
        @(posedge clk);
        do_reset();

        // Program load and run to halt.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0:       load_word(i, 32'h2001_0005);
                1:       load_word(i, 32'h2002_0007);
                2:       load_word(i, 32'hFFFF_FFFF);
                default: load_word(i, 32'h2000_0000 | i);
            endcase
        end
        go();
        chk("load_pc0", out_pc, 32'h0);
        enable = 1;
        tick();
        chk("run_i0", out_instruccion, 32'h2001_0005);
        chk("run_pcb0", out_pc_branch, 32'd4);
        tick();
        chk("run_i1", out_instruccion, 32'h2002_0007);
        chk("run_pcb1", out_pc_branch, 32'd8);
        tick();
        chk("run_halt_i", out_instruccion, 32'hFFFF_FFFF);
        chk("run_halt_pcb", out_pc_branch, 32'd12);
        chk("run_halt_flag", {31'b0, out_halt_flag_d}, 32'd1);
        flag_jump = 1; pc_jump = 32'h40;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_pc_frozen", out_pc, 32'd12);
        end
        clear_in();

        // Stall, jump, branch-vs-jump, step mode.
        do_reset();
        load_word(2, 32'h0000_0002);
        go();
        enable = 1;
        tick();
        tick();
        chk("pre_stall_pc", out_pc, 32'd8);
        saved_pc = out_instruccion;
        stall_flag = 1;
        tick();
        tick();
        chk("stall_pc", out_pc, 32'd8);
        chk("stall_instr", out_instruccion, saved_pc);
        stall_flag = 0;
        tick();
        chk("unstall_pc", out_pc, 32'd12);
        tick();
        chk("pre_jump_pc", out_pc, 32'd16);
        flag_jump = 1; pc_jump = 32'h40;
        #1 chk("jump_flush", {31'b0, flush}, 32'd1);
        tick();
        chk("jump_pc", out_pc, 32'h40);
        chk("jump_nop", out_instruccion, 32'h0);
        flag_branch = 1; pc_branch_target = 32'h80; stall_flag = 1;
        tick();
        chk("br_over_jump_pc", out_pc, 32'h80);
        chk("br_over_jump_nop", out_instruccion, 32'h0);
        flag_branch = 0; flag_jump = 0; stall_flag = 0;
        enable = 0;
        saved_pc = out_pc;
        for (int k = 0; k < 5; k++) tick();
        chk("step_idle_pc", out_pc, saved_pc);
        step = 1;
        tick();
        step = 0;
        chk("step_pc", out_pc, saved_pc + 32'd4);
        tick();
        chk("step_once_pc", out_pc, saved_pc + 32'd4);
        enable = 1;
        flag_jump_register = 1; pc_jump_register = 32'hFFFF_FFFC;
        tick();
        flag_jump_register = 0;
        tick();
        chk("wrap_pc", out_pc, 32'h0);
        chk("wrap_instr", out_instruccion, 32'h2000_00FF);
        tick();

        // Reset mid-run, restart from preserved memory.
        do_reset();
        go();
        chk("restart_pc", out_pc, 32'h0);
        enable = 1;
        tick();
        chk("restart_i0", out_instruccion, 32'h2001_0005);
        chk("restart_pc4", out_pc, 32'd4);

        // Randomized episodes.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int k = 0; k < 20; k++) begin
                load_word($urandom_range(0, 31),
                          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom()));
            end
            go();
            for (int c = 0; c < 80; c++) begin
                enable             = ($urandom_range(0, 3) != 0);
                step               = ($urandom_range(0, 3) == 0);
                stall_flag         = ($urandom_range(0, 4) == 0);
                flag_branch        = ($urandom_range(0, 9) == 0);
                flag_jump          = ($urandom_range(0, 9) == 0);
                flag_jump_register = ($urandom_range(0, 9) == 0);
                pc_branch_target   = 32'($urandom_range(0, 40)) << 2;
                pc_jump            = 32'($urandom_range(0, 40)) << 2;
                pc_jump_register   = ($urandom_range(0, 7) == 0) ? 32'($urandom())
                                                                 : 32'($urandom_range(0, 40)) << 2;
                dbg_we             = ($urandom_range(0, 5) == 0);
                dbg_addr           = 8'($urandom_range(0, 255));
                dbg_data           = 32'hFFFF_FFFF;
                load_done          = ($urandom_range(0, 5) == 0);
                tick();
            end
            clear_in();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register, the instruction memory and the IF/ID pipeline latch. It feeds `ID_EX` with `PC+4` and the fetched instruction, and honours that stage's stall, jump and flush requests. It also supports debug loading of the program, halt detection and single-step execution.

## Interface
- `len_data`, 32: data/instruction/PC width.
- `mem_depth`, 256: instruction memory depth in words.
- `addr_bits`, 8: `$clog2(mem_depth)`, word-address width.
- `clk`  in  1  clock; all state updates on the negedge.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  1 = run continuously; 0 = step mode.
- `step`  in  1  one-cycle pulse; advances one fetch in step mode.
- `dbg_we`  in  1  debug write to instruction memory; legal only in LOAD state.
- `dbg_addr`  in  addr_bits  debug word address.
- `dbg_data`  in  len_data  debug instruction word.
- `load_done`  in  1  pulse; leaves LOAD state.
- `stall_flag`  in  1  hazard stall from `ID_EX`.
- `flag_jump`, `flag_jump_register`  in  1 each  jump requests from `ID_EX`.
- `pc_jump`, `pc_jump_register`  in  len_data each  jump targets.
- `flag_branch`  in  1  taken branch resolved in EX.
- `pc_branch_target`  in  len_data  branch target.
- `out_pc_branch`  out  len_data  latched `PC+4`.
- `out_instruccion`  out  len_data  latched instruction.
- `flush`  out  1  combinational; 1 while a redirect is applied.
- `out_halt_flag_d`  out  1  halt seen, registered.
- `out_pc`  out  len_data  current PC (debug).

## Operation
- States: LOAD (after reset), RUN, HALTED.
  - LOAD→RUN on `load_done`.
  - RUN→HALTED when the fetched word is `32'hFFFFFFFF`.
  - HALTED is left only by reset.
- In LOAD, `dbg_we` writes `mem[dbg_addr]` on the negedge. The PC is held at 0. `dbg_we` outside LOAD is ignored.
- Fetch advance:
  - In RUN with `enable`=1, a fetch is attempted every negedge.
  - In RUN with `enable`=0, a fetch is attempted only on a negedge where `step`=1.
- Next-PC priority, highest first:
  1. reset
  2. HALTED (hold)
  3. `flag_branch` → `pc_branch_target`
  4. `flag_jump_register` → `pc_jump_register`
  5. `flag_jump` → `pc_jump`
  6. `stall_flag` (hold)
  7. `PC+4`
- A branch overrides a jump because the branch belongs to the older instruction.
- A redirect (items 3–5) sets `flush`=1. The IF/ID latch then loads NOP (all zero) instead of the fetched word.
- A redirect wins over `stall_flag` in the same cycle.
- Under stall (no redirect), the PC and the IF/ID latch both hold.
- Memory read is combinational: `mem[PC[addr_bits+1:2]]`. PC bits [1:0] are ignored. The PC wraps modulo 2^`len_data`; the address wraps modulo `mem_depth`.
- Halt detection:
  - The halt word is latched into IF/ID unchanged and `out_halt_flag_d` is set.
  - From then on, the PC and the latch are frozen and `flush` is 0.
  - A redirect arriving in the same cycle the halt word is fetched takes priority: the halt word is flushed and the state stays RUN.

## Timing
- Reset values: PC 0; `out_pc_branch` 0; `out_instruccion` 0; `out_halt_flag_d` 0; state LOAD; memory contents unchanged.
- Latency: the instruction at PC appears on `out_instruccion` after the first negedge that advances. `out_pc_branch` is PC+4 on that same edge.
- `flush` is combinational from the flag inputs and the state. It is 0 in LOAD and HALTED.
- Reset asserted mid-RUN returns to LOAD immediately. Memory is preserved, so RUN can resume after `load_done` without reloading.
- A `step` pulse in RUN with `enable`=1 has no extra effect. `step` in LOAD or HALTED is ignored.

## Structure
- Shared package `mips_pkg`:
  - state encoding (LOAD/RUN/HALTED)
  - `HALT_WORD = 32'hFFFFFFFF`
  - `NOP_WORD = 0`
  - `PC_STEP = 4`
- One sub-module, `instr_mem`: dual-use memory with a synchronous write port and a combinational read port.
- PC and next-PC mux, state machine and IF/ID latch live in `if_stage`.

## Test plan
- Load `mem[0..2]` = {`0x20010005`, `0x20020007`, `0xFFFFFFFF`}, pulse `load_done`, `enable`=1 → `out_instruccion` is `0x20010005` (`out_pc_branch`=4), then `0x20020007` (8), then `0xFFFFFFFF` (12) with `out_halt_flag_d`=1; PC stays at 12 for all later edges.
- In RUN at PC=8, hold `stall_flag` for 2 edges → PC stays 8 and `out_instruccion` is unchanged; on release PC becomes 12.
- At PC=16, assert `flag_jump`, `pc_jump`=`0x40` → `flush`=1, latch = 0, next PC = `0x40`.
- `flag_branch` (target `0x80`) and `flag_jump` (target `0x40`) in the same cycle, with `stall_flag`=1 → PC = `0x80`, latch = 0.
- `enable`=0 → PC is unchanged over 5 edges; one `step` pulse → PC +4 exactly once.
- Assert reset mid-RUN, then pulse `load_done` without reloading → all outputs are 0 during reset; afterwards PC restarts at 0 and re-fetches the preserved `mem[0]`.
